// File: rtl/mem_pkg.sv
// Shared types and constants for the I/D memory arbiter.
// FSM encoding, default line size and the line-base helper.
package mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BURST_I = 2'd1,
        ST_BURST_D = 2'd2
    } state_t;

    localparam int LINE_WORDS_DEF = 4;
    localparam int WORD_OFF       = 2;

    function automatic logic [31:0] line_base(
        input logic [31:0] addr,
        input int          cnt_w
    );
        logic [31:0] mask;
        mask      = (32'd1 << (cnt_w + WORD_OFF)) - 32'd1;
        line_base = addr & ~mask;
    endfunction

endpackage

// File: rtl/mem_burst_cnt.sv
// Beat counter and in-line word address generator for one burst.
// The offset is OR-ed onto a cleared base, so it never carries into the tag.
module mem_burst_cnt
    import mem_pkg::*;
#(
    parameter int LINE_WORDS = LINE_WORDS_DEF
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_load,
    input  logic        i_adv,
    input  logic [31:0] i_addr,
    output logic [31:0] o_addr,
    output logic        o_last
);

    localparam int CNT_W = $clog2(LINE_WORDS);

    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_base;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt  <= '0;
            r_base <= '0;
        end else if (i_load) begin
            r_cnt  <= '0;
            r_base <= line_base(i_addr, CNT_W);
        end else if (i_adv) begin
            r_cnt  <= r_cnt + CNT_W'(1);
        end
    end

    assign o_addr = r_base
                  | {{(32-CNT_W-WORD_OFF){1'b0}}, r_cnt, {WORD_OFF{1'b0}}};
    assign o_last = (r_cnt == CNT_W'(LINE_WORDS - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter between I/D cache miss paths and a word-wide memory bus.
// Each grant runs one full-line burst; read beats return one cycle after handshake.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int LINE_WORDS = LINE_WORDS_DEF
) (
    input  logic        iCLK,
    input  logic        iRSTn,
    input  logic        iIreqVALID,
    input  logic [31:0] iIreqADDR,
    output logic        oIreqREADY,
    output logic [31:0] oIrdDATA,
    output logic        oIrdVALID,
    output logic        oIrdLAST,
    input  logic        iDreqVALID,
    input  logic        iDreqWE,
    input  logic [31:0] iDreqADDR,
    input  logic [31:0] iDwrDATA,
    output logic        oDreqREADY,
    output logic        oDwrACK,
    output logic [31:0] oDrdDATA,
    output logic        oDrdVALID,
    output logic        oDrdLAST,
    output logic        oMemVALID,
    output logic        oMemWE,
    output logic [31:0] oMemADDR,
    output logic [31:0] oMemWDATA,
    input  logic        iMemREADY,
    input  logic [31:0] iMemRDATA
);

    state_t      r_state;
    state_t      w_next;
    logic        r_rr_last;
    logic        r_we;
    logic        r_ireq_ready;
    logic        r_dreq_ready;
    logic [31:0] r_irdata;
    logic        r_irvalid;
    logic        r_irlast;
    logic [31:0] r_drdata;
    logic        r_drvalid;
    logic        r_drlast;

    logic        w_grant_i;
    logic        w_grant_d;
    logic        w_busy;
    logic        w_hs;
    logic        w_last;
    logic        w_in_i;
    logic        w_in_d;
    logic [31:0] w_addr;
    logic [31:0] w_req_addr;

    mem_burst_cnt #(
        .LINE_WORDS (LINE_WORDS)
    ) u_cnt (
        .i_clk   (iCLK),
        .i_rst_n (iRSTn),
        .i_load  (w_grant_i | w_grant_d),
        .i_adv   (w_hs),
        .i_addr  (w_req_addr),
        .o_addr  (w_addr),
        .o_last  (w_last)
    );

    assign w_in_i     = (r_state == ST_BURST_I);
    assign w_in_d     = (r_state == ST_BURST_D);
    assign w_busy     = w_in_i | w_in_d;
    assign w_hs       = oMemVALID & iMemREADY;
    assign w_req_addr = w_grant_i ? iIreqADDR : iDreqADDR;

    // r_rr_last = 1 means D was granted last; a tie goes to the other side.
    always_comb begin
        w_grant_i = 1'b0;
        w_grant_d = 1'b0;
        if (r_state == ST_IDLE) begin
            if (iIreqVALID && iDreqVALID) begin
                w_grant_i = r_rr_last;
                w_grant_d = !r_rr_last;
            end else begin
                w_grant_i = iIreqVALID;
                w_grant_d = iDreqVALID;
            end
        end
    end

    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            r_state      <= ST_IDLE;
            r_rr_last    <= 1'b1;
            r_we         <= 1'b0;
            r_ireq_ready <= 1'b0;
            r_dreq_ready <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_ireq_ready <= w_grant_i;
            r_dreq_ready <= w_grant_d;
            if (w_grant_i) begin
                r_rr_last <= 1'b0;
                r_we      <= 1'b0;
            end else if (w_grant_d) begin
                r_rr_last <= 1'b1;
                r_we      <= iDreqWE;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_grant_i)      w_next = ST_BURST_I;
                else if (w_grant_d) w_next = ST_BURST_D;
            end
            ST_BURST_I, ST_BURST_D: begin
                if (w_hs && w_last) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        oMemVALID = 1'b0;
        oMemWE    = 1'b0;
        oMemADDR  = '0;
        oMemWDATA = '0;
        if (w_busy) begin
            oMemVALID = 1'b1;
            oMemWE    = r_we;
            oMemADDR  = w_addr;
            if (r_we) oMemWDATA = iDwrDATA;
        end
    end

    assign oDwrACK = w_hs & r_we;

    // Returned read beats and end-of-burst markers, one cycle after handshake.
    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            r_irdata  <= '0;
            r_irvalid <= 1'b0;
            r_irlast  <= 1'b0;
            r_drdata  <= '0;
            r_drvalid <= 1'b0;
            r_drlast  <= 1'b0;
        end else begin
            r_irvalid <= w_hs & w_in_i;
            r_irlast  <= w_hs & w_in_i & w_last;
            r_drvalid <= w_hs & w_in_d & !r_we;
            r_drlast  <= w_hs & w_in_d & w_last;
            if (w_hs && w_in_i)          r_irdata <= iMemRDATA;
            if (w_hs && w_in_d && !r_we) r_drdata <= iMemRDATA;
        end
    end

    assign oIreqREADY = r_ireq_ready;
    assign oDreqREADY = r_dreq_ready;
    assign oIrdDATA   = r_irdata;
    assign oIrdVALID  = r_irvalid;
    assign oIrdLAST   = r_irlast;
    assign oDrdDATA   = r_drdata;
    assign oDrdVALID  = r_drvalid;
    assign oDrdLAST   = r_drlast;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: bursts, round-robin, wait states, reset.
module tb_mem_arbiter;

    localparam int LW = 4;

    logic        iCLK = 1'b0;
    logic        iRSTn = 1'b0;
    logic        iIreqVALID = 1'b0;
    logic [31:0] iIreqADDR = '0;
    logic        oIreqREADY;
    logic [31:0] oIrdDATA;
    logic        oIrdVALID;
    logic        oIrdLAST;
    logic        iDreqVALID = 1'b0;
    logic        iDreqWE = 1'b0;
    logic [31:0] iDreqADDR = '0;
    logic [31:0] iDwrDATA = '0;
    logic        oDreqREADY;
    logic        oDwrACK;
    logic [31:0] oDrdDATA;
    logic        oDrdVALID;
    logic        oDrdLAST;
    logic        oMemVALID;
    logic        oMemWE;
    logic [31:0] oMemADDR;
    logic [31:0] oMemWDATA;
    logic        iMemREADY = 1'b0;
    logic [31:0] iMemRDATA;

    logic [7:0]  pat = 8'hFF;
    int          n_chk = 0;
    int          n_err = 0;

    always #5 iCLK = ~iCLK;

    // Memory model: word content is a tag plus the low address bits.
    assign iMemRDATA = {16'hBEEF, oMemADDR[15:0]};

    mem_arbiter #(.LINE_WORDS(LW)) dut (
        .iCLK       (iCLK),
        .iRSTn      (iRSTn),
        .iIreqVALID (iIreqVALID),
        .iIreqADDR  (iIreqADDR),
        .oIreqREADY (oIreqREADY),
        .oIrdDATA   (oIrdDATA),
        .oIrdVALID  (oIrdVALID),
        .oIrdLAST   (oIrdLAST),
        .iDreqVALID (iDreqVALID),
        .iDreqWE    (iDreqWE),
        .iDreqADDR  (iDreqADDR),
        .iDwrDATA   (iDwrDATA),
        .oDreqREADY (oDreqREADY),
        .oDwrACK    (oDwrACK),
        .oDrdDATA   (oDrdDATA),
        .oDrdVALID  (oDrdVALID),
        .oDrdLAST   (oDrdLAST),
        .oMemVALID  (oMemVALID),
        .oMemWE     (oMemWE),
        .oMemADDR   (oMemADDR),
        .oMemWDATA  (oMemWDATA),
        .iMemREADY  (iMemREADY),
        .iMemRDATA  (iMemRDATA)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge iCLK);
        #1;
    endtask

    task automatic check_outs_zero(input string tag);
        check({tag, "_ctl"}, {oIreqREADY, oIrdVALID, oIrdLAST, oDreqREADY,
              oDwrACK, oDrdVALID, oDrdLAST, oMemVALID, oMemWE}, 0);
        check({tag, "_addr"}, oMemADDR, 0);
        check({tag, "_wdata"}, oMemWDATA, 0);
        check({tag, "_irdata"}, oIrdDATA, 0);
        check({tag, "_drdata"}, oDrdDATA, 0);
    endtask

    task automatic do_reset();
        iRSTn      = 1'b0;
        iIreqVALID = 1'b0;
        iDreqVALID = 1'b0;
        iDreqWE    = 1'b0;
        iMemREADY  = 1'b0;
        iDwrDATA   = '0;
        pat        = 8'hFF;
        repeat (2) @(posedge iCLK);
        #1;
        check_outs_zero("rst");
        iRSTn = 1'b1;
    endtask

    task automatic check_rd(input bit is_d, input bit we, input bit pend,
                            input logic [31:0] a, input bit fin);
        logic [31:0] d;
        bit          rd;
        d  = {16'hBEEF, a[15:0]};
        rd = pend && !we;
        if (is_d) begin
            check("d_rd_valid", oDrdVALID, rd);
            check("d_rd_last", oDrdLAST, pend && fin);
            if (rd) check("d_rd_data", oDrdDATA, d);
            check("i_rd_quiet", {oIrdVALID, oIrdLAST}, 0);
        end else begin
            check("i_rd_valid", oIrdVALID, rd);
            check("i_rd_last", oIrdLAST, pend && fin);
            if (rd) check("i_rd_data", oIrdDATA, d);
            check("d_rd_quiet", {oDrdVALID, oDrdLAST}, 0);
        end
    endtask

    // Follows one granted burst from its READY pulse to the idle bubble.
    task automatic watch_burst(input bit is_d, input bit we,
                               input logic [31:0] base, input int raise_i);
        int beats;
        int cyc;
        bit pend;
        int pidx;
        beats = 0;
        cyc   = 0;
        pend  = 1'b0;
        pidx  = 0;
        step();
        if (is_d) iDreqVALID = 1'b0;
        else      iIreqVALID = 1'b0;
        iMemREADY = pat[0];
        iDwrDATA  = 32'hA0;
        #1;
        check(is_d ? "dreq_ready" : "ireq_ready",
              is_d ? oDreqREADY : oIreqREADY, 1);
        check("other_ready", is_d ? oIreqREADY : oDreqREADY, 0);
        while (beats < LW && cyc < 40) begin
            if (cyc > 0) begin
                step();
                iMemREADY = pat[cyc % 8];
                iDwrDATA  = 32'hA0 + beats;
                if (cyc == raise_i) begin
                    iIreqVALID = 1'b1;
                    iIreqADDR  = 32'h6004;
                end
                #1;
                check("ready_busy", {oIreqREADY, oDreqREADY}, 0);
            end
            check_rd(is_d, we, pend, base + 4 * pidx, 1'b0);
            check("mem_valid", oMemVALID, 1);
            check("mem_addr", oMemADDR, base + 4 * beats);
            check("mem_we", oMemWE, we);
            check("mem_wdata", oMemWDATA, we ? 32'hA0 + beats : 0);
            check("wr_ack", oDwrACK, we & iMemREADY);
            pend = iMemREADY;
            pidx = beats;
            if (iMemREADY) beats++;
            cyc++;
        end
        check("burst_beats", beats, LW);
        step();
        iMemREADY = 1'b1;
        #1;
        check_rd(is_d, we, pend, base + 4 * pidx, 1'b1);
        check("mem_idle", oMemVALID, 0);
        check("idle_ack", oDwrACK, 0);
        check("ready_bubble", {oIreqREADY, oDreqREADY}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end

    initial begin
        do_reset();

        // Single I refill from mid-line address
        step();
        iIreqVALID = 1'b1;
        iIreqADDR  = 32'h0000_1008;
        #1;
        check("idle_mem_valid", oMemVALID, 0);
        watch_burst(1'b0, 1'b0, 32'h1000, -1);
        step();
        #1;
        check("i_rd_hold", oIrdDATA, 32'hBEEF_100C);
        check("i_rd_pulse_off", {oIrdVALID, oIrdLAST}, 0);

        // First tie after reset goes to I, D follows after one bubble
        do_reset();
        step();
        iIreqVALID = 1'b1;
        iIreqADDR  = 32'h1000;
        iDreqVALID = 1'b1;
        iDreqWE    = 1'b0;
        iDreqADDR  = 32'h2008;
        #1;
        watch_burst(1'b0, 1'b0, 32'h1000, -1);
        watch_burst(1'b1, 1'b0, 32'h2000, -1);

        // After a lone I grant, the next tie goes to D
        step();
        iIreqVALID = 1'b1;
        iIreqADDR  = 32'h1010;
        #1;
        watch_burst(1'b0, 1'b0, 32'h1010, -1);
        step();
        iIreqVALID = 1'b1;
        iIreqADDR  = 32'h1024;
        iDreqVALID = 1'b1;
        iDreqWE    = 1'b0;
        iDreqADDR  = 32'h203C;
        #1;
        watch_burst(1'b1, 1'b0, 32'h2030, -1);
        watch_burst(1'b0, 1'b0, 32'h1020, -1);

        // D writeback
        step();
        iDreqVALID = 1'b1;
        iDreqWE    = 1'b1;
        iDreqADDR  = 32'h2000;
        #1;
        watch_burst(1'b1, 1'b1, 32'h2000, -1);

        // Wait states on a write then a read: 0,0,1,0,1,1,0,1
        pat = 8'b1011_0100;
        step();
        iDreqVALID = 1'b1;
        iDreqWE    = 1'b1;
        iDreqADDR  = 32'h2044;
        #1;
        watch_burst(1'b1, 1'b1, 32'h2040, -1);
        step();
        iIreqVALID = 1'b1;
        iIreqADDR  = 32'h3004;
        #1;
        watch_burst(1'b0, 1'b0, 32'h3000, -1);
        pat = 8'hFF;

        // Reset in the middle of an I refill
        step();
        iIreqVALID = 1'b1;
        iIreqADDR  = 32'h3008;
        #1;
        step();
        iIreqVALID = 1'b0;
        iMemREADY  = 1'b1;
        #1;
        check("mr_ready", oIreqREADY, 1);
        check("mr_addr0", oMemADDR, 32'h3000);
        step();
        #1;
        check("mr_addr1", oMemADDR, 32'h3004);
        step();
        #1;
        check("mr_addr2", oMemADDR, 32'h3008);
        check("mr_rd_valid", oIrdVALID, 1);
        iRSTn = 1'b0;
        #1;
        check_outs_zero("async_rst");
        do_reset();
        step();
        iDreqVALID = 1'b1;
        iDreqWE    = 1'b0;
        iDreqADDR  = 32'h4010;
        #1;
        watch_burst(1'b1, 1'b0, 32'h4010, -1);

        // I request raised during a D burst waits for the bubble
        step();
        iDreqVALID = 1'b1;
        iDreqWE    = 1'b1;
        iDreqADDR  = 32'h5000;
        #1;
        watch_burst(1'b1, 1'b1, 32'h5000, 2);
        watch_burst(1'b0, 1'b0, 32'h6000, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
